psum_requant: RTL and testbench



---
 rtl/psum_requant_pkg.sv | 35 +++
 rtl/psum_requant_relu_requant.sv | 40 ++++
 rtl/psum_requant.sv | 110 +++++++++++
 tb/tb_psum_requant.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/psum_requant_pkg.sv
// psum_requant_pkg: shared types and helpers for the partial-sum requantizer.
//   state_e  : FSM encoding (ACC -> QUANT -> OUT)
//   CNT_BW   : width of the saturating group-psum counter
//   act_max  : largest unsigned activation for a given width
//   sat_add  : signed add clamped to a w-bit two's complement range
package psum_requant_pkg;

  typedef enum logic [1:0] {
    ACC   = 2'd0,
    QUANT = 2'd1,
    OUT   = 2'd2
  } state_e;

  localparam int CNT_BW = 8;

  function automatic longint act_max(input int w);
    return (longint'(1) << w) - longint'(1);
  endfunction

  // Operands must already fit in w bits (w <= 63); the 64-bit sum cannot wrap.
  function automatic logic signed [63:0] sat_add(input logic signed [63:0] a,
                                                 input logic signed [63:0] b,
                                                 input int                 w);
    logic signed [63:0] s;
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    s  = a + b;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (w - 1));
    if (s > hi)      return hi;
    else if (s < lo) return lo;
    else             return s;
  endfunction

endpackage

// File: rtl/psum_requant_relu_requant.sv
// relu_requant: combinational ReLU + right-shift requantization + clip.
//   acc   : signed accumulated group sum
//   shift : right-shift amount
//   act   : unsigned activation, clipped to act_max(bw)
//   sat   : shifted value exceeded act_max(bw)
// Build option: define PSUM_REQUANT_ROUND_EN for round-half-up, else truncate.
module relu_requant
  import psum_requant_pkg::*;
#(
  parameter int bw       = 4,
  parameter int acc_bw   = 16,
  parameter int shift_bw = 4
) (
  input  logic signed [acc_bw-1:0]   acc,
  input  logic        [shift_bw-1:0] shift,
  output logic        [bw-1:0]       act,
  output logic                       sat
);

  // One extra bit so the rounding add can never overflow.
  localparam logic [acc_bw:0] ACT_MAX_V = (acc_bw+1)'(act_max(bw));

  logic [acc_bw:0] r;
  logic [acc_bw:0] r_adj;
  logic [acc_bw:0] q;

  assign r = acc[acc_bw-1] ? '0 : {1'b0, acc};

`ifdef PSUM_REQUANT_ROUND_EN
  localparam logic [acc_bw:0] ONE = {{acc_bw{1'b0}}, 1'b1};
  assign r_adj = (shift == '0) ? r : r + (ONE << (shift - 1'b1));
`else
  assign r_adj = r;
`endif

  assign q   = r_adj >> shift;
  assign sat = (q > ACT_MAX_V);
  assign act = sat ? ACT_MAX_V[bw-1:0] : q[bw-1:0];

endmodule

// File: rtl/psum_requant.sv
// psum_requant: accumulates a group of signed partial sums, then emits one
// ReLU'd, right-shift-requantized, saturated unsigned activation.
//   clk, reset_n          : clock, async active-low reset
//   in_valid/in_ready     : psum handshake (in_psum, in_last, cfg_shift)
//   out_valid/out_ready   : activation handshake (out_act, out_sat)
//   busy                  : group in progress
// Build option: PSUM_REQUANT_ROUND_EN selects round-half-up in requant.
module psum_requant
  import psum_requant_pkg::*;
#(
  parameter int bw       = 4,
  parameter int psum_bw  = 9,
  parameter int acc_bw   = 16,
  parameter int shift_bw = 4
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic signed [psum_bw-1:0]  in_psum,
  input  logic                       in_last,
  input  logic        [shift_bw-1:0] cfg_shift,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic        [bw-1:0]       out_act,
  output logic                       out_sat,
  output logic                       busy
);

  state_e                    state_q, state_d;
  logic signed [acc_bw-1:0]  acc_q, acc_d;
  logic        [CNT_BW-1:0]  cnt_q, cnt_d;
  logic        [shift_bw-1:0] shift_q, shift_d;
  logic        [bw-1:0]      act_q, act_d;
  logic                      sat_q, sat_d;
  logic        [bw-1:0]      rq_act;
  logic                      rq_sat;
  logic                      in_fire;

  assign in_ready  = (state_q == ACC);
  assign out_valid = (state_q == OUT);
  assign in_fire   = in_valid && in_ready;
  assign out_act   = act_q;
  assign out_sat   = sat_q;
  assign busy      = (state_q != ACC) || (cnt_q != '0);

  relu_requant #(
    .bw       (bw),
    .acc_bw   (acc_bw),
    .shift_bw (shift_bw)
  ) u_rq (
    .acc   (acc_q),
    .shift (shift_q),
    .act   (rq_act),
    .sat   (rq_sat)
  );

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    shift_d = shift_q;
    act_d   = act_q;
    sat_d   = sat_q;
    case (state_q)
      ACC: begin
        if (in_fire) begin
          acc_d = acc_bw'(sat_add({{(64-acc_bw){acc_q[acc_bw-1]}}, acc_q},
                                  {{(64-psum_bw){in_psum[psum_bw-1]}}, in_psum},
                                  acc_bw));
          cnt_d = (&cnt_q) ? cnt_q : cnt_q + 1'b1;
          if (in_last) begin
            shift_d = cfg_shift;
            state_d = QUANT;
          end
        end
      end
      QUANT: begin
        act_d   = rq_act;
        sat_d   = rq_sat;
        acc_d   = '0;
        cnt_d   = '0;
        state_d = OUT;
      end
      OUT: begin
        if (out_ready) state_d = ACC;
      end
      default: state_d = ACC;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ACC;
      acc_q   <= '0;
      cnt_q   <= '0;
      shift_q <= '0;
      act_q   <= '0;
      sat_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
      act_q   <= act_d;
      sat_q   <= sat_d;
    end
  end

endmodule

// File: tb/tb_psum_requant.sv
module tb_psum_requant;
  localparam int BW = 4, PBW = 9, ABW = 16, SBW = 4, ABW_S = 10;
  localparam int AMAX = (1 << BW) - 1;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  logic                  in_valid, in_ready, in_last, out_valid, out_ready, out_sat, busy;
  logic signed [PBW-1:0] in_psum;
  logic [SBW-1:0]        cfg_shift;
  logic [BW-1:0]         out_act;

  logic                  in_valid_n, in_ready_n, in_last_n, out_valid_n, out_ready_n, out_sat_n, busy_n;
  logic signed [PBW-1:0] in_psum_n;
  logic [SBW-1:0]        cfg_shift_n;
  logic [BW-1:0]         out_act_n;

  int nvec = 0;
  int nerr = 0;

  psum_requant #(.bw(BW), .psum_bw(PBW), .acc_bw(ABW), .shift_bw(SBW)) u_dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_psum(in_psum), .in_last(in_last), .cfg_shift(cfg_shift),
    .out_valid(out_valid), .out_ready(out_ready), .out_act(out_act),
    .out_sat(out_sat), .busy(busy));

  psum_requant #(.bw(BW), .psum_bw(PBW), .acc_bw(ABW_S), .shift_bw(SBW)) u_dut_small (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid_n), .in_ready(in_ready_n),
    .in_psum(in_psum_n), .in_last(in_last_n), .cfg_shift(cfg_shift_n),
    .out_valid(out_valid_n), .out_ready(out_ready_n), .out_act(out_act_n),
    .out_sat(out_sat_n), .busy(busy_n));

  // Reference: saturating running sum, ReLU, (rounded) shift, clip.
  function automatic void model(input int ps[$], input int sh, input int accw,
                                output int act, output int sat);
    longint a, hi, lo, r, q;
    hi = (longint'(1) << (accw - 1)) - 1;
    lo = -hi - 1;
    a  = 0;
    foreach (ps[i]) begin
      a = a + ps[i];
      if (a > hi) a = hi;
      if (a < lo) a = lo;
    end
    r = (a < 0) ? 0 : a;
`ifdef PSUM_REQUANT_ROUND_EN
    if (sh > 0) r = r + (longint'(1) << (sh - 1));
`endif
    q   = r >> sh;
    sat = (q > AMAX) ? 1 : 0;
    act = (q > AMAX) ? AMAX : int'(q);
  endfunction

  // Present one psum at a negedge; returns at the negedge after its transfer.
  task automatic push(input int p, input bit last, input int sh, input string tag);
    int k = 0;
    while (!in_ready && k < 50) begin @(negedge clk); k++; end
    nvec++;
    if (in_ready !== 1'b1) begin
      nerr++; $display("FAIL %s in_ready: got %b want 1", tag, in_ready);
    end
    in_valid  = 1'b1;
    in_psum   = PBW'(p);
    in_last   = last;
    cfg_shift = last ? SBW'(sh) : SBW'($urandom_range(0, 15));
    @(negedge clk);
    in_valid  = 1'b0;
    in_last   = 1'b0;
    cfg_shift = SBW'($urandom_range(0, 15));
  endtask

  // Full group: psums, latency check, bp cycles of back-pressure, handshake.
  task automatic run_group(input int ps[$], input int sh, input int bp, input string tag);
    int eact, esat;
    model(ps, sh, ABW, eact, esat);
    out_ready = 1'b0;
    for (int i = 0; i < ps.size(); i++) push(ps[i], (i == ps.size() - 1), sh, tag);
    nvec++;
    if (out_valid !== 1'b0 || in_ready !== 1'b0 || busy !== 1'b1) begin
      nerr++; $display("FAIL %s quant-cycle: valid=%b rdy=%b busy=%b want 0 0 1", tag, out_valid, in_ready, busy);
    end
    out_ready = (bp == 0);
    @(negedge clk);
    nvec++;
    if (out_valid !== 1'b1) begin
      nerr++; $display("FAIL %s latency: out_valid=%b want 1", tag, out_valid);
    end
    nvec++;
    if (out_act !== BW'(eact) || out_sat !== esat[0]) begin
      nerr++; $display("FAIL %s result: act=%0d sat=%b want act=%0d sat=%0d", tag, out_act, out_sat, eact, esat);
    end
    for (int c = 0; c < bp; c++) begin
      @(negedge clk);
      nvec++;
      if (out_valid !== 1'b1 || out_act !== BW'(eact) || out_sat !== esat[0] || in_ready !== 1'b0) begin
        nerr++; $display("FAIL %s hold: valid=%b act=%0d sat=%b rdy=%b want 1 %0d %0d 0", tag, out_valid, out_act, out_sat, in_ready, eact, esat);
      end
    end
    out_ready = 1'b1;
    @(negedge clk);
    nvec++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
      nerr++; $display("FAIL %s release: valid=%b rdy=%b busy=%b want 0 1 0", tag, out_valid, in_ready, busy);
    end
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    in_valid = 0; in_last = 0; in_psum = '0; cfg_shift = '0; out_ready = 0;
    in_valid_n = 0; in_last_n = 0; in_psum_n = '0; cfg_shift_n = '0; out_ready_n = 1;
    repeat (3) @(negedge clk);
    nvec++;
    if (in_ready !== 1 || out_valid !== 0 || out_act !== '0 || out_sat !== 0 || busy !== 0) begin
      nerr++; $display("FAIL reset: rdy=%b valid=%b act=%0d sat=%b busy=%b want 1 0 0 0 0", in_ready, out_valid, out_act, out_sat, busy);
    end
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    int q[$];
    q = {10, 20, -3};
    run_group(q, 2, 0, "basic");
  endtask

  task automatic test_saturation();
    int q[$];
    q = {100}; run_group(q, 2, 0, "sat_clip");
    q = {60};  run_group(q, 2, 0, "sat_edge");
  endtask

  task automatic test_negative();
    int q[$];
    q = {-200, 50}; run_group(q, 2, 0, "relu_neg");
    q = {7};        run_group(q, 0, 0, "shift0");
    q = {200};      run_group(q, 0, 0, "shift0_sat");
  endtask

  task automatic test_back_pressure();
    int q[$];
    q = {33, -1, 9}; run_group(q, 1, 4, "backpressure");
    q = {5};         run_group(q, 0, 0, "after_bp");
  endtask

  task automatic test_acc_saturation();
    int eact, esat, q[$];
    q = {255, 255, 255};
    model(q, 5, ABW_S, eact, esat);
    foreach (q[i]) begin
      in_valid_n = 1; in_psum_n = PBW'(q[i]); in_last_n = (i == 2); cfg_shift_n = 4'd5;
      @(negedge clk);
    end
    in_valid_n = 0; in_last_n = 0;
    @(negedge clk);
    nvec++;
    if (out_valid_n !== 1 || out_act_n !== BW'(eact) || out_sat_n !== esat[0]) begin
      nerr++; $display("FAIL acc_sat: valid=%b act=%0d sat=%b want 1 %0d %0d", out_valid_n, out_act_n, out_sat_n, eact, esat);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    int q[$];
    // Reset while holding a saturated result in OUT.
    push(100, 1'b1, 2, "rst_out");
    @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    nvec++;
    if (out_valid !== 0 || out_act !== '0 || out_sat !== 0 || in_ready !== 1 || busy !== 0) begin
      nerr++; $display("FAIL async_reset_out: valid=%b act=%0d sat=%b rdy=%b busy=%b want 0 0 0 1 0", out_valid, out_act, out_sat, in_ready, busy);
    end
    @(negedge clk); reset_n = 1'b1; @(negedge clk);
    // Reset mid-group discards prior psums.
    push(40, 1'b0, 0, "rst_mid");
    push(40, 1'b0, 0, "rst_mid");
    #2 reset_n = 1'b0;
    #1;
    nvec++;
    if (busy !== 0 || in_ready !== 1) begin
      nerr++; $display("FAIL async_reset_mid: busy=%b rdy=%b want 0 1", busy, in_ready);
    end
    @(negedge clk); reset_n = 1'b1; @(negedge clk);
    q = {8};
    run_group(q, 0, 0, "post_reset");
  endtask

  task automatic test_random();
    int q[$];
    for (int g = 0; g < 40; g++) begin
      q.delete();
      for (int i = 0; i < int'($urandom_range(1, 6)); i++)
        q.push_back(int'($urandom_range(0, 511)) - 256);
      run_group(q, int'($urandom_range(0, 9)), int'($urandom_range(0, 3)), "random");
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_saturation();
    test_negative();
    test_back_pressure();
    test_acc_saturation();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
